// File: rtl/fml_wb_bridge.sv
// Wishbone classic (32-bit) slave to FML 4x64-bit burst master.
// A one-line read buffer serves repeat reads to the same 32-byte line.
module fml_wb_bridge #(
  parameter int unsigned adr_width = 28
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  output logic                 wb_ack_o,
  output logic [adr_width-1:0] fml_adr,
  output logic                 fml_stb,
  output logic                 fml_we,
  input  logic                 fml_ack,
  output logic [7:0]           fml_sel,
  output logic [63:0]          fml_do,
  input  logic [63:0]          fml_di
);

  localparam int unsigned LW = adr_width - 5;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_RDBURST = 3'd2;
  localparam logic [2:0] S_WRBURST = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic                 ack_q, ack_d;
  logic [31:0]          rdat_q, rdat_d;
  logic                 fstb_q, fstb_d;
  logic                 fwe_q, fwe_d;
  logic [adr_width-1:0] fadr_q, fadr_d;

  logic [LW-1:0]        tag_q, tag_d;
  logic [LW-1:0]        line_q, line_d;
  logic [1:0]           beat_q, beat_d;
  logic                 half_q, half_d;
  logic                 we_q, we_d;
  logic [31:0]          dat_q, dat_d;
  logic [3:0]           sel_q, sel_d;
  logic [63:0]          buf_q [4];
  logic [63:0]          buf_d [4];

  logic                 req;
  logic [LW-1:0]        in_line;
  logic [1:0]           in_beat;
  logic                 in_half;
  logic [63:0]          wr_word;
  logic [7:0]           wr_mask;
  logic [63:0]          rd_word;
  logic [63:0]          hit_word;
  logic                 wr_active;
  logic [1:0]           wr_k;
  logic                 unused_adr;

  assign unused_adr = ^{wb_adr_i >> adr_width, wb_adr_i[1:0]};

  assign req     = wb_cyc_i & wb_stb_i & ~ack_q;
  assign in_line = wb_adr_i[adr_width-1:5];
  assign in_beat = wb_adr_i[4:3];
  assign in_half = wb_adr_i[2];

  assign wr_word  = {dat_q, dat_q};
  assign wr_mask  = half_q ? {4'b0000, sel_q} : {sel_q, 4'b0000};
  assign hit_word = buf_q[in_beat];
  // The final read beat is not in the buffer yet when the ack word is chosen.
  assign rd_word  = (beat_q == 2'd3) ? fml_di : buf_q[beat_q];

  // Write beat 0 goes out on the fml_ack cycle itself, while still in REQ.
  assign wr_active = (state_q == S_WRBURST) || ((state_q == S_REQ) && fml_ack && we_q);
  assign wr_k      = (state_q == S_WRBURST) ? cnt_q : 2'd0;

  always_comb begin
    fml_sel = '0;
    fml_do  = '0;
    if (wr_active && (wr_k == beat_q)) begin
      fml_sel = wr_mask;
      fml_do  = wr_word;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ack_d   = 1'b0;
    rdat_d  = rdat_q;
    fstb_d  = fstb_q;
    fwe_d   = fwe_q;
    fadr_d  = fadr_q;
    tag_d   = tag_q;
    line_d  = line_q;
    beat_d  = beat_q;
    half_d  = half_q;
    we_d    = we_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    buf_d   = buf_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          line_d = in_line;
          beat_d = in_beat;
          half_d = in_half;
          we_d   = wb_we_i;
          dat_d  = wb_dat_i;
          sel_d  = wb_sel_i;
          if (!wb_we_i && valid_q && (in_line == tag_q)) begin
            rdat_d  = in_half ? hit_word[31:0] : hit_word[63:32];
            state_d = S_ACK;
          end else begin
            fadr_d  = {in_line, 5'b00000};
            fstb_d  = 1'b1;
            fwe_d   = wb_we_i;
            state_d = S_REQ;
            if (!wb_we_i) valid_d = 1'b0;
          end
        end
      end
      S_REQ: begin
        if (fml_ack) begin
          fstb_d = 1'b0;
          fwe_d  = 1'b0;
          cnt_d  = 2'd1;
          if (we_q) begin
            if (valid_q && (tag_q == line_q)) begin
              for (int unsigned i = 0; i < 8; i++) begin
                if (wr_mask[i]) buf_d[beat_q][8*i +: 8] = wr_word[8*i +: 8];
              end
            end
            state_d = S_WRBURST;
          end else begin
            buf_d[0] = fml_di;
            state_d  = S_RDBURST;
          end
        end
      end
      S_RDBURST: begin
        buf_d[cnt_q] = fml_di;
        cnt_d        = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          tag_d   = line_q;
          valid_d = 1'b1;
          rdat_d  = half_q ? rd_word[31:0] : rd_word[63:32];
          state_d = S_ACK;
        end
      end
      S_WRBURST: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_ACK;
      end
      S_ACK: begin
        ack_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
      fstb_q  <= 1'b0;
      fwe_q   <= 1'b0;
      fadr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
      fstb_q  <= fstb_d;
      fwe_q   <= fwe_d;
      fadr_q  <= fadr_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    tag_q  <= tag_d;
    line_q <= line_d;
    beat_q <= beat_d;
    half_q <= half_d;
    we_q   <= we_d;
    dat_q  <= dat_d;
    sel_q  <= sel_d;
    buf_q  <= buf_d;
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = rdat_q;
  assign fml_stb  = fstb_q;
  assign fml_we   = fwe_q;
  assign fml_adr  = fadr_q;

endmodule
